// File: rtl/timed_output_scheduler.sv
// timed_output_scheduler
// Queues {timestamp, data} events in a circular FIFO and releases the head
// as a one-cycle write strobe once the system counter reaches its timestamp.
// Configuration macro: SCHEDULER_LATE_DROP_EN
//   defined   -> heads whose timestamp is already past are discarded and
//                flagged on late_error
//   undefined -> heads whose timestamp is now or past are issued normally,
//                and late_error is held at 0
module timed_output_scheduler #(
   parameter int NUM_DATA   = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int TS_WIDTH   = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [TS_WIDTH-1:0] counter,
   input  logic                in_valid,
   input  logic [TS_WIDTH-1:0] in_timestamp,
   input  logic [NUM_DATA-1:0] in_data,
   input  logic                flush,
   input  logic                clear_error,
   output logic                out_wr_en,
   output logic [NUM_DATA-1:0] out_data,
   output logic                fifo_full,
   output logic                fifo_empty,
   output logic                overflow_error,
   output logic                late_error
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

   // Entry storage; contents are never reset, only pointers and count are.
   logic [TS_WIDTH-1:0] r_mem_ts   [FIFO_DEPTH];
   logic [NUM_DATA-1:0] r_mem_data [FIFO_DEPTH];

   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;
   logic                r_out_wr_en;
   logic [NUM_DATA-1:0] r_out_data;
   logic                r_overflow;

   logic                w_full;
   logic                w_empty;
   logic                w_write;
   logic                w_overflow;
   logic                w_issue;
   logic                w_late;
   logic                w_pop;
   logic [TS_WIDTH-1:0] w_head_ts;
   logic [NUM_DATA-1:0] w_head_data;

   // Status is derived from the registered count, so a pop in the same cycle
   // never makes room for a write that arrives while the FIFO is full.
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);

   // The head is read combinationally so match and pop land in one cycle.
   // A freshly written entry only becomes visible once count has advanced,
   // i.e. from the cycle after its write.
   assign w_head_ts   = r_mem_ts[r_rd_ptr];
   assign w_head_data = r_mem_data[r_rd_ptr];

   // Flush wins over both the write request and any pop in its cycle.
   assign w_write    = in_valid && !w_full && !flush;
   assign w_overflow = in_valid &&  w_full && !flush;

`ifdef SCHEDULER_LATE_DROP_EN
   assign w_issue = !w_empty && !flush && (w_head_ts == counter);
   assign w_late  = !w_empty && !flush && (w_head_ts <  counter);
`else
   assign w_issue = !w_empty && !flush && (w_head_ts <= counter);
   assign w_late  = 1'b0;
`endif

   // Only one entry leaves per cycle, either issued or discarded as late.
   assign w_pop = w_issue || w_late;

   // Store the incoming entry at the write pointer.
   always_ff @(posedge clk) begin
      if (w_write && !reset) begin
         r_mem_ts[r_wr_ptr]   <= in_timestamp;
         r_mem_data[r_wr_ptr] <= in_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_write) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered output strobe one cycle after a match; data holds between strobes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_wr_en <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_out_wr_en <= w_issue;
         if (w_issue) begin
            r_out_data <= w_head_data;
         end
      end
   end

   // Sticky overflow flag; a new overflow in the clearing cycle keeps it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_overflow) begin
         r_overflow <= 1'b1;
      end else if (clear_error) begin
         r_overflow <= 1'b0;
      end
   end

`ifdef SCHEDULER_LATE_DROP_EN
   logic r_late;

   // Sticky late flag; a late discard in the clearing cycle keeps it set.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_late <= 1'b0;
      end else if (w_late) begin
         r_late <= 1'b1;
      end else if (clear_error) begin
         r_late <= 1'b0;
      end
   end

   assign late_error = r_late;
`else
   assign late_error = 1'b0;
`endif

   assign out_wr_en      = r_out_wr_en;
   assign out_data       = r_out_data;
   assign fifo_full      = w_full;
   assign fifo_empty     = w_empty;
   assign overflow_error = r_overflow;

endmodule

// File: tb/tb_timed_output_scheduler.sv
// Testbench for timed_output_scheduler.
// A queue-based reference model tracks the expected FIFO contents, strobe,
// data and sticky flags; one compare process checks every cycle, and the
// directed scenarios add hand-computed literal expectations.
// Honors SCHEDULER_LATE_DROP_EN the same way the design does.
module tb_timed_output_scheduler;

   localparam int ND = 8;
   localparam int D  = 16;
   localparam int TW = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [TW-1:0] counter;
   logic          in_valid;
   logic [TW-1:0] in_timestamp;
   logic [ND-1:0] in_data;
   logic          flush;
   logic          clear_error;
   logic          out_wr_en;
   logic [ND-1:0] out_data;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overflow_error;
   logic          late_error;

   int n_cmp = 0;
   int n_bad = 0;

   timed_output_scheduler #(
      .NUM_DATA   (ND),
      .FIFO_DEPTH (D),
      .TS_WIDTH   (TW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .counter        (counter),
      .in_valid       (in_valid),
      .in_timestamp   (in_timestamp),
      .in_data        (in_data),
      .flush          (flush),
      .clear_error    (clear_error),
      .out_wr_en      (out_wr_en),
      .out_data       (out_data),
      .fifo_full      (fifo_full),
      .fifo_empty     (fifo_empty),
      .overflow_error (overflow_error),
      .late_error     (late_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [TW-1:0] ts;
      logic [ND-1:0] d;
   } ent_t;

   ent_t          q[$];
   bit            m_valid = 0;
   bit            m_wr    = 0;
   logic [ND-1:0] m_data  = '0;
   bit            m_ovf   = 0;
   bit            m_late  = 0;
   bit            m_issue;
   bit            m_drop;
   bit            m_full;

   always @(posedge clk) begin
      if (reset) begin
         q.delete();
         m_wr    = 0;
         m_data  = '0;
         m_ovf   = 0;
         m_late  = 0;
         m_valid = 1;
      end else if (m_valid) begin
         m_full  = (q.size() == D);
         m_issue = 0;
         m_drop  = 0;
         if (!flush && q.size() > 0) begin
`ifdef SCHEDULER_LATE_DROP_EN
            if (q[0].ts == counter)     m_issue = 1;
            else if (q[0].ts < counter) m_drop  = 1;
`else
            if (q[0].ts <= counter) m_issue = 1;
`endif
         end
         m_wr = m_issue;
         if (m_issue) m_data = q[0].d;
         if (in_valid && m_full && !flush) m_ovf = 1;
         else if (clear_error)             m_ovf = 0;
         if (m_drop)           m_late = 1;
         else if (clear_error) m_late = 0;
         if (flush) begin
            q.delete();
         end else begin
            if (m_issue || m_drop) void'(q.pop_front());
            if (in_valid && !m_full) q.push_back('{ts: in_timestamp, d: in_data});
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         check("out_wr_en", {63'd0, out_wr_en}, {63'd0, m_wr});
         check("out_data", 64'(out_data), 64'(m_data));
         check("fifo_full", {63'd0, fifo_full}, {63'd0, (q.size() == D)});
         check("fifo_empty", {63'd0, fifo_empty}, {63'd0, (q.size() == 0)});
         check("overflow_error", {63'd0, overflow_error}, {63'd0, m_ovf});
         check("late_error", {63'd0, late_error}, {63'd0, m_late});
         if (out_wr_en) $display("issue data=%02h counter=%0d", out_data, counter);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
      counter = counter + 64'd1;
   endtask

   task automatic write(input logic [TW-1:0] ts, input logic [ND-1:0] d);
      in_valid     = 1'b1;
      in_timestamp = ts;
      in_data      = d;
      cycle();
      in_valid     = 1'b0;
   endtask

   int            pulses;
   logic [ND-1:0] first_d;
   logic [ND-1:0] last_d;
   logic [TW-1:0] prev_ts;

   initial begin
      reset = 1'b1; counter = '0; in_valid = 1'b0; in_timestamp = '0;
      in_data = '0; flush = 1'b0; clear_error = 1'b0;
      cycle();
      cycle();
      check("rst_empty", {63'd0, fifo_empty}, 64'd1);
      check("rst_full", {63'd0, fifo_full}, 64'd0);
      check("rst_wr_en", {63'd0, out_wr_en}, 64'd0);
      check("rst_ovf", {63'd0, overflow_error}, 64'd0);
      reset = 1'b0;

      // basic issue
      counter = 64'd50;
      write(64'd100, 8'h01);
      check("basic_not_empty", {63'd0, fifo_empty}, 64'd0);
      while (counter < 64'd100) cycle();
      check("basic_pre", {63'd0, out_wr_en}, 64'd0);
      cycle();
      check("basic_pulse", {63'd0, out_wr_en}, 64'd1);
      check("basic_data", 64'(out_data), 64'h01);
      cycle();
      check("basic_one_cycle", {63'd0, out_wr_en}, 64'd0);
      check("basic_hold", 64'(out_data), 64'h01);

      // overflow and error-clear priority
      counter = 64'd200;
      for (int i = 0; i < D; i++) write(64'd1000, ND'(8'h10 + i));
      check("ovf_full", {63'd0, fifo_full}, 64'd1);
      check("ovf_err_pre", {63'd0, overflow_error}, 64'd0);
      write(64'd1000, 8'hAA);
      check("ovf_err", {63'd0, overflow_error}, 64'd1);
      in_valid = 1'b1; clear_error = 1'b1; in_timestamp = 64'd1000; in_data = 8'hBB;
      cycle();
      in_valid = 1'b0;
      check("prio_set_wins", {63'd0, overflow_error}, 64'd1);
      cycle();
      clear_error = 1'b0;
      check("clear_alone", {63'd0, overflow_error}, 64'd0);
      pulses = 0; first_d = '0; last_d = '0;
      while (counter < 64'd1040) begin
         cycle();
         if (out_wr_en) begin
            if (pulses == 0) first_d = out_data;
            last_d = out_data;
            pulses++;
         end
      end
`ifdef SCHEDULER_LATE_DROP_EN
      check("ovf_pulses", 64'(pulses), 64'd1);
      check("ovf_first", 64'(first_d), 64'h10);
      check("ovf_late_err", {63'd0, late_error}, 64'd1);
`else
      check("ovf_pulses", 64'(pulses), 64'd16);
      check("ovf_first", 64'(first_d), 64'h10);
      check("ovf_last", 64'(last_d), 64'h1F);
`endif
      check("ovf_drained", {63'd0, fifo_empty}, 64'd1);

      // late entry
      reset = 1'b1; cycle(); reset = 1'b0;
      counter = 64'd20;
      write(64'd10, 8'h5C);
      cycle();
`ifdef SCHEDULER_LATE_DROP_EN
      check("late_no_wr", {63'd0, out_wr_en}, 64'd0);
      check("late_err", {63'd0, late_error}, 64'd1);
`else
      check("late_wr", {63'd0, out_wr_en}, 64'd1);
      check("late_data", 64'(out_data), 64'h5C);
      check("late_err_tied", {63'd0, late_error}, 64'd0);
`endif
      cycle();
      check("late_wr_gone", {63'd0, out_wr_en}, 64'd0);

      // flush
      counter = 64'd300;
      write(64'd500, 8'h31);
      write(64'd501, 8'h32);
      write(64'd502, 8'h33);
      check("flush_pre_empty", {63'd0, fifo_empty}, 64'd0);
      counter = 64'd400; flush = 1'b1;
      cycle();
      flush = 1'b0;
      check("flush_empty", {63'd0, fifo_empty}, 64'd1);
      pulses = 0;
      while (counter <= 64'd600) begin
         cycle();
         if (out_wr_en) pulses++;
      end
      check("flush_no_pulses", 64'(pulses), 64'd0);

      // reset on a match cycle
      counter = 64'd690;
      write(64'd700, 8'h77);
      while (counter < 64'd700) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("rstmid_wr", {63'd0, out_wr_en}, 64'd0);
      check("rstmid_data", 64'(out_data), 64'd0);
      check("rstmid_empty", {63'd0, fifo_empty}, 64'd1);
      check("rstmid_full", {63'd0, fifo_full}, 64'd0);
      check("rstmid_ovf", {63'd0, overflow_error}, 64'd0);
      check("rstmid_late", {63'd0, late_error}, 64'd0);

      // randomized traffic
      prev_ts = counter;
      for (int k = 0; k < 3000; k++) begin
         in_valid = ($urandom_range(0, 99) < 45);
         if ($urandom_range(0, 3) == 0) in_timestamp = prev_ts;
         else in_timestamp = counter + 64'($urandom_range(0, 30)) - 64'd4;
         prev_ts     = in_timestamp;
         in_data     = ND'($urandom);
         flush       = ($urandom_range(0, 199) == 0);
         clear_error = ($urandom_range(0, 99) < 3);
         reset       = ($urandom_range(0, 499) == 0);
         cycle();
      end
      in_valid = 1'b0; flush = 1'b0; clear_error = 1'b0; reset = 1'b0;
      for (int k = 0; k < 40; k++) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/timed_output_scheduler.md
TIMED_OUTPUT_SCHEDULER -- requirements
Module: timed_output_scheduler

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  NUM_DATA, 1, output payload width;
  FIFO_DEPTH, 16, entry count, power of two, at least 2;
  TS_WIDTH, 64, timestamp width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  sole clock, all logic on rising edge;
  reset  in  1  synchronous, active-high;
  counter  in  TS_WIDTH  system time, advances one per clk;
  in_valid  in  1  write request;
  in_timestamp  in  TS_WIDTH  event time;
  in_data  in  NUM_DATA  event payload;
  flush  in  1  discard all queued entries;
  clear_error  in  1  clear sticky error flags;
  out_wr_en  out  1  one-cycle write strobe to the downstream output port;
  out_data  out  NUM_DATA  payload qualified by out_wr_en;
  fifo_full  out  1  count == FIFO_DEPTH;
  fifo_empty  out  1  count == 0;
  overflow_error  out  1  sticky, write dropped;
  late_error  out  1  sticky, late entry discarded.
REQ-003 clk and reset SHALL be named clk and reset; reset SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL store {timestamp, data} entries in a circular FIFO with read and write pointers of log2(FIFO_DEPTH) bits that wrap modulo FIFO_DEPTH, plus a count register.
REQ-005 Write acceptance: when in_valid=1 and fifo_full=0, the entry SHALL be written and count SHALL increment in the same cycle.
REQ-006 When in_valid=1 and fifo_full=1, the entry SHALL be dropped and overflow_error SHALL be set. This applies even if a pop occurs in the same cycle, because fifo_full is evaluated on the registered count.
REQ-007 A written entry SHALL be eligible for compare no earlier than the cycle after it is written.
REQ-008 Issue: when fifo_empty=0 and head timestamp == counter, the head SHALL be popped. On the next cycle out_wr_en SHALL be 1 for exactly one cycle and out_data SHALL equal the head data. Latency is one cycle from match.
REQ-009 out_data SHALL hold its last issued value while out_wr_en=0.
REQ-010 At most one entry SHALL pop per cycle. A following entry with an equal timestamp is therefore late by one cycle and is handled per REQ-019.
REQ-011 A simultaneous write and pop SHALL leave count unchanged.
REQ-012 Entries SHALL be issued strictly in FIFO order. There is no reordering; a head with a future timestamp blocks all entries behind it.
REQ-013 Timestamp comparison SHALL be unsigned and full TS_WIDTH, with no wrap handling.
REQ-014 flush=1 SHALL, on that edge:
  - reset both pointers and count to 0;
  - suppress any pop in that cycle;
  - ignore in_valid in that cycle;
  - leave the error flags unchanged.
REQ-015 clear_error=1 SHALL clear overflow_error and late_error. If an error event occurs in the same cycle, the set SHALL win.

Reset
REQ-016 Reset SHALL set the following to 0: pointers, count, out_wr_en, out_data, overflow_error, late_error. After reset fifo_empty=1 and fifo_full=0.
REQ-017 Reset SHALL take priority over flush, in_valid and issue. An in-flight pop SHALL produce no out_wr_en after reset.
REQ-018 FIFO storage contents need not be reset.

Configuration
REQ-019 Macro SCHEDULER_LATE_DROP_EN:
  - Defined: a head with timestamp < counter SHALL be popped without asserting out_wr_en, and late_error SHALL be set.
  - Undefined: a head with timestamp <= counter SHALL be issued per REQ-008, and late_error SHALL be tied to 0.

Verification
REQ-020 Scenario, basic issue: reset; write (ts=100, data=1) with counter=50 -> out_wr_en pulses for one cycle on the cycle after counter=100, with out_data=1.
REQ-021 Scenario, overflow: FIFO_DEPTH=16; write 17 entries with ts=1000 while counter<1000 -> fifo_full=1 after the 16th write, 17th write dropped, overflow_error=1; at counter=1000-1015 the 16 entries issue in order, one per cycle (with LATE_DROP_EN, entries 2-16 are late-dropped and late_error=1).
REQ-022 Scenario, late entry: write (ts=10) when counter=20 -> with the macro, no out_wr_en and late_error=1; without the macro, out_wr_en pulses 2 cycles after the write.
REQ-023 Scenario, flush: write 3 entries (ts=500/501/502); assert flush at counter=400 -> fifo_empty=1 and no out_wr_en through counter=600.
REQ-024 Scenario, error priority: assert clear_error in the same cycle as an overflowing write -> overflow_error remains 1; clear_error alone on the next cycle -> overflow_error=0.
REQ-025 Scenario, reset mid-operation: assert reset on the cycle of a match -> no out_wr_en on the next cycle, and all outputs equal the REQ-016 values.
